// File: rtl/serial_accumulator_pkg.sv
// serial_accumulator_pkg: default widths and FSM encoding for the bit-serial accumulator
package serial_accumulator_pkg;
  localparam int SER_IN_W = 8;
  localparam int SER_ACC_W = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXT, ST_DONE} state_t;
endpackage

// File: rtl/serial_accumulator_full_adder.sv
// full_adder: one-bit adder slice with enable, shared by the serial datapaths
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic en,
  output logic s,
  output logic cout
);
  assign s = en & (a ^ b ^ cin);
  assign cout = en & ((a & b) | (cin & (a ^ b)));
endmodule

// File: rtl/serial_accumulator.sv
// serial_accumulator: LSB-first signed operand added into a rotating accumulator one bit per beat
module serial_accumulator
  import serial_accumulator_pkg::*;
#(
  parameter int IN_W = SER_IN_W,
  parameter int ACC_W = SER_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_first,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             busy,
  output logic             ovf
);
  localparam int CW = $clog2(ACC_W);
  localparam logic [CW-1:0] IN_LAST = CW'(IN_W - 1);
  localparam logic [CW-1:0] ACC_LAST = CW'(ACC_W - 1);
  state_t state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0] cnt;
  logic carry, sign, accept, add, last_in, fa_a, fa_cin, fa_s, fa_cout;
  assign in_ready = (state == ST_IDLE || state == ST_LOAD) && !clr;
  assign accept = in_valid && in_ready;
  assign last_in = state == ST_LOAD && accept && cnt == IN_LAST;
  assign add = (state == ST_IDLE && accept && in_first) || (state == ST_LOAD && accept) || state == ST_EXT;
  // Sign extension feeds the remembered MSB once the operand is exhausted
  assign fa_a = state == ST_EXT ? sign : in_bit;
  assign fa_cin = state == ST_IDLE ? 1'b0 : carry;
  full_adder u_fa (.a(fa_a), .b(acc[0]), .cin(fa_cin), .en(1'b1), .s(fa_s), .cout(fa_cout));
  assign acc_out = acc;
  assign acc_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= clr ? ST_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = add ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_nx = last_in ? (ACC_W > IN_W ? ST_EXT : ST_DONE) : ST_LOAD;
      ST_EXT:  state_nx = cnt == ACC_LAST ? ST_DONE : ST_EXT;
      default: state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sign <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      carry <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (add) begin
        acc <= {fa_s, acc[ACC_W-1:1]};
        carry <= fa_cout;
        cnt <= cnt + 1'b1;
        if (cnt == ACC_LAST) ovf <= ovf | (fa_cin ^ fa_cout);
      end
      if (last_in) sign <= in_bit;
      if (state == ST_DONE) begin
        carry <= 1'b0;
        cnt <= '0;
      end
    end
endmodule

// File: tb/tb_serial_accumulator.sv
// tb_serial_accumulator: randomized and directed checks of two accumulator widths against an integer model
module tb_serial_accumulator;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, in_bit = 0, in_first = 0, sel = 0;
  logic a_ready, a_vld, a_busy, a_ovf, b_ready, b_vld, b_busy, b_ovf;
  logic [15:0] a_acc;
  logic [7:0] b_acc;
  logic in_ready, acc_valid, busy, ovf;
  logic [15:0] acc_out;
  logic signed [15:0] racc = 0;
  bit rovf = 0;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_accumulator #(.IN_W(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & !sel), .in_bit(in_bit),
    .in_first(in_first), .in_ready(a_ready), .acc_out(a_acc), .acc_valid(a_vld),
    .busy(a_busy), .ovf(a_ovf));
  serial_accumulator #(.IN_W(8), .ACC_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid & sel), .in_bit(in_bit),
    .in_first(in_first), .in_ready(b_ready), .acc_out(b_acc), .acc_valid(b_vld),
    .busy(b_busy), .ovf(b_ovf));
  assign in_ready = sel ? b_ready : a_ready;
  assign acc_valid = sel ? b_vld : a_vld;
  assign busy = sel ? b_busy : a_busy;
  assign ovf = sel ? b_ovf : a_ovf;
  assign acc_out = sel ? {8'h00, b_acc} : a_acc;

  task automatic model_add(input logic [7:0] v);
    int s;
    s = int'(racc) + int'($signed(v));
    if (s > 32767 || s < -32768) rovf = 1;
    racc = 16'(s);
  endtask

  task automatic model_clear();
    racc = 0;
    rovf = 0;
  endtask

  task automatic beats(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_bit = v[i];
      in_first = i == 0;
      @(negedge clk);
    end
    in_valid = 0;
    in_first = 0;
  endtask

  task automatic run_op(input logic [7:0] v, input int gap, input string name, output int lat);
    int c0 = 0;
    int n;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!in_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (!in_ready) begin
        fails++;
        $display("FAIL %s ready_timeout: in_ready=%0b required 1", name, in_ready);
      end
      if (i == 0) c0 = cyc;
      in_valid = 1;
      in_bit = v[i];
      in_first = i == 0;
      @(negedge clk);
      in_valid = 0;
      in_first = 0;
      repeat (i < 7 ? gap : 0) @(negedge clk);
    end
    n = 0;
    while (!acc_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!acc_valid) begin
      fails++;
      $display("FAIL %s valid_timeout: acc_valid=%0b required 1", name, acc_valid);
    end
    lat = cyc - c0;
  endtask

  task automatic do_clr();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({acc_out, ovf, acc_valid, busy, in_ready} !== {16'h0, 4'b0001}) begin
      fails++;
      $display("FAIL reset_init: acc=%h ovf=%b vld=%b busy=%b rdy=%b required 0000 0 0 0 1", acc_out, ovf, acc_valid, busy, in_ready);
    end
    rst_n = 1;
    @(negedge clk);
    beats(8'hFF, 3);
    tests++;
    if (busy !== 1'b1 || acc_out === 16'h0) begin
      fails++;
      $display("FAIL reset_midop_pre: busy=%b acc=%h required busy 1 and nonzero acc", busy, acc_out);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({acc_out, ovf, acc_valid, busy, in_ready} !== {16'h0, 4'b0001}) begin
      fails++;
      $display("FAIL reset_midop: acc=%h ovf=%b vld=%b busy=%b rdy=%b required 0000 0 0 0 1", acc_out, ovf, acc_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_basic();
    int lat;
    logic [7:0] ops[2] = '{8'h05, 8'h03};
    logic [15:0] exp_acc[2] = '{16'h0005, 16'h0008};
    do_clr();
    model_clear();
    for (int k = 0; k < 2; k++) begin
      run_op(ops[k], 0, "basic", lat);
      model_add(ops[k]);
      tests++;
      if (lat !== 16) begin
        fails++;
        $display("FAIL basic_latency: got %0d required 16", lat);
      end
      tests++;
      if (acc_out !== exp_acc[k] || acc_out !== racc) begin
        fails++;
        $display("FAIL basic_acc: got %h required %h", acc_out, exp_acc[k]);
      end
    end
  endtask

  task automatic test_sign_extend();
    int lat;
    do_clr();
    model_clear();
    run_op(8'hFF, 0, "sext", lat);
    tests++;
    if (acc_out !== 16'hFFFF) begin
      fails++;
      $display("FAIL sext_neg: got %h required FFFF", acc_out);
    end
    run_op(8'h02, 0, "sext", lat);
    tests++;
    if (acc_out !== 16'h0001 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL sext_wrap: got acc=%h ovf=%b required 0001 0", acc_out, ovf);
    end
    model_add(8'hFF);
    model_add(8'h02);
  endtask

  task automatic test_protocol();
    int lat;
    @(negedge clk);
    in_valid = 1;
    in_first = 0;
    in_bit = 1;
    repeat (2) @(negedge clk);
    in_valid = 0;
    tests++;
    if (busy !== 1'b0 || acc_out !== racc) begin
      fails++;
      $display("FAIL protocol_nofirst: busy=%b acc=%h required 0 %h", busy, acc_out, racc);
    end
    run_op(8'h7F, 2, "stall", lat);
    model_add(8'h7F);
    tests++;
    if (lat !== 30) begin
      fails++;
      $display("FAIL stall_latency: got %0d required 30", lat);
    end
    tests++;
    if (acc_out !== racc) begin
      fails++;
      $display("FAIL stall_acc: got %h required %h", acc_out, racc);
    end
  endtask

  task automatic test_clr_mid();
    int lat, pulses = 0;
    @(negedge clk);
    beats(8'h55, 3);
    clr = 1;
    in_valid = 1;
    in_first = 1;
    in_bit = 1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_ready: got %b required 0", in_ready);
    end
    @(negedge clk);
    clr = 0;
    in_valid = 0;
    in_first = 0;
    tests++;
    if (busy !== 1'b0 || acc_out !== 16'h0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL clr_state: busy=%b acc=%h ovf=%b required 0 0000 0", busy, acc_out, ovf);
    end
    repeat (20) begin
      if (acc_valid) pulses++;
      @(negedge clk);
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL clr_novalid: got %0d pulses required 0", pulses);
    end
    model_clear();
    run_op(8'h04, 0, "clr_next", lat);
    model_add(8'h04);
    tests++;
    if (acc_out !== 16'h0004 || acc_out !== racc) begin
      fails++;
      $display("FAIL clr_next_acc: got %h required 0004", acc_out);
    end
  endtask

  task automatic test_random();
    int lat, gap;
    logic [7:0] v;
    do_clr();
    model_clear();
    for (int k = 0; k < 24; k++) begin
      v = 8'($urandom);
      gap = $urandom_range(0, 2);
      run_op(v, gap, "random", lat);
      model_add(v);
      tests++;
      if (acc_out !== racc || ovf !== rovf || lat !== 16 + 7 * gap) begin
        fails++;
        $display("FAIL random_%0d: op=%h acc=%h ovf=%b lat=%0d required %h %b %0d", k, v, acc_out, ovf, lat, racc, rovf, 16 + 7 * gap);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    sel = 1;
    do_clr();
    run_op(8'h7F, 0, "ovf", lat);
    run_op(8'h01, 0, "ovf", lat);
    tests++;
    if (acc_out !== 16'h0080 || ovf !== 1'b1 || lat !== 8) begin
      fails++;
      $display("FAIL ovf_set: acc=%h ovf=%b lat=%0d required 0080 1 8", acc_out, ovf, lat);
    end
    run_op(8'h01, 0, "ovf", lat);
    tests++;
    if (acc_out !== 16'h0081 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_sticky: acc=%h ovf=%b required 0081 1", acc_out, ovf);
    end
    @(negedge clk);
    do_clr();
    tests++;
    if (acc_out !== 16'h0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clr: acc=%h ovf=%b required 0000 0", acc_out, ovf);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_extend();
    test_protocol();
    test_clr_mid();
    test_random();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
